// File: rtl/module_input_conditioner.sv
// -----------------------------------------------------------------------------
// module_input_conditioner
//
// Front-end stage between the board switches and module_top. Every raw switch
// bit is passed through a two-flop synchroniser and then debounced. A new level
// reaches clean_o only after the synchronised sample has differed from the
// current clean level for CNT_MAX consecutive clocks. Downstream logic (the
// Hamming RX decoder and the display) therefore never sees bounce or
// metastable samples.
//
// Bus layout (WIDTH = 11):
//   raw_i[10:4] / clean_o[10:4] : 7-bit Hamming codeword e
//   raw_i[3:0]  / clean_o[3:0]  : 4-bit data word i
//
// Ports:
//   clk      in   1      system clock
//   rst_n    in   1      asynchronous active-low reset
//   raw_i    in   WIDTH  unsynchronised switch levels
//   clean_o  out  WIDTH  debounced levels
//   stable_o out  1      1 when every synchronised bit matches its clean bit
//   chg_o    out  1      one-cycle pulse on the edge where clean_o changes
//
// Build option:
//   INPUT_CONDITIONER_CHG_PULSE_EN - when defined, the change-detect register
//   behind chg_o is built. When undefined, chg_o is tied to 0 and no
//   change-detect logic exists. clean_o and stable_o are the same in both
//   builds.
// -----------------------------------------------------------------------------
module module_input_conditioner #(
    parameter int WIDTH   = 11,
    parameter int CNT_MAX = 270000,
    parameter int CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] clean_o,
    output logic             stable_o,
    output logic             chg_o
);

    // Terminal count: the counter never exceeds this value, so it cannot wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Two-flop synchroniser for every raw switch bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= {WIDTH{1'b0}};
            s2_q <= {WIDTH{1'b0}};
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Per-bit debounce decision. Any cycle where s2 agrees with the clean
    // level restarts the count, so only an unbroken run of CNT_MAX differing
    // samples is accepted.
    always_comb begin
        clean_d = clean_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (s2_q[b] == clean_q[b]) begin
                cnt_d[b] = CNT_ZERO;
            end else if (cnt_q[b] == CNT_LAST) begin
                clean_d[b] = s2_q[b];
                cnt_d[b]   = CNT_ZERO;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_ONE;
            end
        end
    end

    // Debounce counters and clean levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clean_q <= {WIDTH{1'b0}};
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= CNT_ZERO;
            end
        end else begin
            clean_q <= clean_d;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign clean_o = clean_q;

    // Built only from registers, so this output cannot glitch on raw_i activity.
    assign stable_o = (s2_q == clean_q);

`ifdef INPUT_CONDITIONER_CHG_PULSE_EN
    logic chg_q;

    // Registers a pulse on the same edge that any clean bit toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= (clean_d != clean_q);
        end
    end

    assign chg_o = chg_q;
`else
    assign chg_o = 1'b0;
`endif

endmodule

// File: doc/module_input_conditioner.md
# module_input_conditioner

- Front-end stage between the board switches and `module_top`.
- Synchronises and debounces the raw switch bus. Bits [10:4] carry the 7-bit Hamming codeword (`e`); bits [3:0] carry the 4-bit data word (`i`).
- Presents only settled values downstream, so the RX decoder and display never see bounce or metastable samples.
- Raises a status flag while any bit is still settling.

## Interface

Parameters:
- `WIDTH`, default 11: raw input bus width.
- `CNT_MAX`, default 270000: consecutive stable cycles needed to accept a new value (10 ms at 27 MHz). Legal range is CNT_MAX ≥ 1.
- `CNT_W`, default $clog2(CNT_MAX+1): counter width. Derived; never overridden.

Ports:
- `clk`, input, 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n`, input, 1: asynchronous active-low reset.
- `raw_i`, input, WIDTH: unsynchronised switch levels.
- `clean_o`, output, WIDTH: debounced levels; [10:4] drive `e`, [3:0] drive `i`.
- `stable_o`, output, 1: 1 when every synchronised bit equals its `clean_o` bit.
- `chg_o`, output, 1: one-cycle pulse when `clean_o` changes (see Configuration).

## Operation

- Per bit: a 2-flop synchroniser (s1 → s2), a CNT_W counter, and a clean flop.
- At each rising edge, per bit:
  - If s2 == clean: counter ← 0.
  - Else, if counter == CNT_MAX−1: clean ← s2 and counter ← 0.
  - Else: counter ← counter + 1.
- Bits are fully independent. Several bits may update on the same edge or on different edges.
- `stable_o` = AND over bits of (s2 == clean). It is combinational from registers, so it is glitch-free.
- `chg_o` is registered. It is 1 on exactly the edge where at least one clean bit toggles, and 0 otherwise.
- Reset (asserted asynchronously, held while `rst_n`=0) sets:
  - s1, s2, counters, clean, `chg_o` = 0
  - `clean_o` = 0, `stable_o` = 1, `chg_o` = 0

## Timing

- Latency: `raw_i` bit changes and holds before rising edge n → s2 updates at edge n+1 → `clean_o` updates at edge n+CNT_MAX+1. With CNT_MAX=1 this is edge n+2.
- Rejection: any s2 excursion shorter than CNT_MAX cycles is discarded. The counter clears on the first cycle s2 returns to the clean value, and `clean_o` is unchanged.
- Bounce: each return to the clean value restarts the count. Acceptance happens CNT_MAX cycles after the last transition.
- Counter never exceeds CNT_MAX−1. No wrap-around is possible.
- Reset mid-count:
  - All counts are lost and `clean_o` returns to 0.
  - After release, a held nonzero input is accepted at edge CNT_MAX+2 after the first post-release edge: 2 synchroniser cycles plus CNT_MAX.
- Reset release is asynchronous to clk. The design is functionally safe because all state restarts from 0.
- `stable_o` falls the cycle s2 first differs from clean. It rises the same cycle `clean_o` updates, or the cycle s2 returns to the clean value.

## Configuration

- Macro: `INPUT_CONDITIONER_CHG_PULSE_EN`.
- Defined: the `chg_o` register and compare logic are built, and `chg_o` behaves as described above.
- Undefined: the port still exists, `chg_o` is tied to 0, and no change-detect logic is synthesised. `clean_o` and `stable_o` are identical in both builds.

## Test plan

All scenarios use CNT_MAX=4, WIDTH=11.

- Reset: drive `raw_i`=11'h7FF with `rst_n`=0 for 5 cycles → `clean_o`=0, `stable_o`=1, `chg_o`=0 throughout.
- Step acceptance: after reset, set `raw_i`=11'h5A3 before edge n and hold → `clean_o`=11'h5A3 from edge n+5, `stable_o`=0 for edges n+1..n+4, `chg_o`=1 only at edge n+5 (macro defined).
- Glitch rejection: pulse bit 0 high for 3 cycles, then low → `clean_o` stays 0, `chg_o` never asserts, `stable_o` returns to 1.
- Bounce: toggle bit 10 high/low/high with 2-cycle spacing, then hold high → `clean_o`[10]=1 exactly 5 edges after the final toggle's launch edge.
- Staggered multi-bit: raise bit 2 at edge n and bit 7 at edge n+2 → bit 2 updates at n+5, bit 7 updates at n+7, with two separate `chg_o` pulses.
- Reset mid-count: raise bit 3, assert `rst_n` for 1 cycle at count 2 while still holding bit 3 → `clean_o`=0 immediately, then bit 3 is accepted 6 edges after release. With the macro undefined, `chg_o` stays 0 throughout.
